// File: rtl/bolucu_pkg.sv
// Shared constants and state encoding for the iterative divider.
package bolucu_pkg;

  localparam int unsigned VERI_BIT = 32;
  localparam int unsigned LATENCY  = VERI_BIT + 2;
  localparam int unsigned BOL_ADIM = LATENCY - 2;
  localparam int unsigned SAYAC_W  = $clog2(VERI_BIT);

  localparam logic [VERI_BIT-1:0] DIV0_BOLUM = '1;
  localparam logic [VERI_BIT-1:0] OVF_BOLUM  = {1'b1, {(VERI_BIT-1){1'b0}}};

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    HAZIRLA = 2'd1,
    BOL     = 2'd2,
    DUZELT  = 2'd3
  } durum_t;

endpackage

// File: rtl/bolucu_adim.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module bolucu_adim
  import bolucu_pkg::*;
(
  input  logic [VERI_BIT-1:0] i_r,
  input  logic                i_q_msb,
  input  logic [VERI_BIT-1:0] i_d,
  output logic [VERI_BIT-1:0] o_r,
  output logic                o_q_bit
);

  logic [VERI_BIT:0]   w_kaydir;
  logic [VERI_BIT+1:0] w_fark;
  logic                w_borc;
  logic                w_unused_ust;

  assign w_kaydir = {i_r, i_q_msb};
  assign w_fark   = {1'b0, w_kaydir} - {2'b00, i_d};
  assign w_borc   = w_fark[VERI_BIT+1];

  // Borrow out means the shifted remainder is below the divisor: restore.
  always_comb begin
    o_q_bit = ~w_borc;
    o_r     = w_borc ? w_kaydir[VERI_BIT-1:0] : w_fark[VERI_BIT-1:0];
  end

  // The top bit of either candidate is always zero when it is selected.
  assign w_unused_ust = w_kaydir[VERI_BIT] ^ w_fark[VERI_BIT];

endmodule

// File: rtl/bolucu_seq.sv
// Radix-2 restoring 32-bit divider, signed/unsigned, fixed LATENCY handshake.
module bolucu_seq
  import bolucu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [VERI_BIT-1:0] islec0_i,
  input  logic [VERI_BIT-1:0] islec1_i,
  input  logic                isaretli_i,
  input  logic                islem_gecerli_i,
  output logic                hazir_o,
  input  logic                iptal_i,
  output logic [VERI_BIT-1:0] bolum_o,
  output logic [VERI_BIT-1:0] kalan_o,
  output logic                sonuc_gecerli_o
);

  durum_t              r_durum, w_durum_sonraki;
  logic [SAYAC_W-1:0]  r_sayac;
  logic [VERI_BIT-1:0] r_islec0, r_islec1, r_q, r_r, r_d, r_bolum, r_kalan;
  logic                r_isaretli, r_q_neg, r_r_neg, r_div0, r_ovf;
  logic                r_hazir, r_sonuc_gecerli;
  logic                w_kabul, w_sonuc_yukle, w_hazir_sonraki, w_q_bit;
  logic [VERI_BIT-1:0] w_abs0, w_abs1, w_r_sonraki, w_bolum_son, w_kalan_son;

  assign w_abs0 = (r_isaretli && r_islec0[VERI_BIT-1]) ? -r_islec0 : r_islec0;
  assign w_abs1 = (r_isaretli && r_islec1[VERI_BIT-1]) ? -r_islec1 : r_islec1;

  bolucu_adim u_adim (
    .i_r     (r_r),
    .i_q_msb (r_q[VERI_BIT-1]),
    .i_d     (r_d),
    .o_r     (w_r_sonraki),
    .o_q_bit (w_q_bit)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_durum <= BOSTA;
    else         r_durum <= w_durum_sonraki;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    w_durum_sonraki = r_durum;
    if (iptal_i) begin
      w_durum_sonraki = BOSTA;
    end else begin
      case (r_durum)
        BOSTA:   if (islem_gecerli_i) w_durum_sonraki = HAZIRLA;
        HAZIRLA: w_durum_sonraki = BOL;
        BOL:     if (r_sayac == '0) w_durum_sonraki = DUZELT;
        DUZELT:  w_durum_sonraki = BOSTA;
        default: w_durum_sonraki = BOSTA;
      endcase
    end
  end

  // FSM control outputs feeding the registered ports and datapath.
  always_comb begin
    w_kabul         = (r_durum == BOSTA) && islem_gecerli_i && !iptal_i;
    w_sonuc_yukle   = (r_durum == DUZELT) && !iptal_i;
    w_hazir_sonraki = (w_durum_sonraki == BOSTA);
  end

  // Final result: sign fix, then special cases take priority.
  always_comb begin
    w_bolum_son = r_q_neg ? -r_q : r_q;
    w_kalan_son = r_r_neg ? -r_r : r_r;
    if (r_div0) begin
      w_bolum_son = DIV0_BOLUM;
      w_kalan_son = r_islec0;
    end else if (r_ovf) begin
      w_bolum_son = OVF_BOLUM;
      w_kalan_son = '0;
    end
  end

  // Operand capture, preparation and the iterative shift/subtract.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_islec0   <= '0;
      r_islec1   <= '0;
      r_isaretli <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_sayac    <= '0;
    end else begin
      case (r_durum)
        BOSTA: begin
          if (w_kabul) begin
            r_islec0   <= islec0_i;
            r_islec1   <= islec1_i;
            r_isaretli <= isaretli_i;
            r_q_neg    <= isaretli_i & (islec0_i[VERI_BIT-1] ^ islec1_i[VERI_BIT-1]);
            r_r_neg    <= isaretli_i & islec0_i[VERI_BIT-1];
          end
        end
        HAZIRLA: begin
          r_q     <= w_abs0;
          r_d     <= w_abs1;
          r_r     <= '0;
          r_div0  <= (r_islec1 == '0);
          r_ovf   <= r_isaretli && (r_islec0 == OVF_BOLUM) && (r_islec1 == '1);
          r_sayac <= SAYAC_W'(BOL_ADIM - 1);
        end
        BOL: begin
          r_q     <= {r_q[VERI_BIT-2:0], w_q_bit};
          r_r     <= w_r_sonraki;
          r_sayac <= r_sayac - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and result outputs; results hold until the next load.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hazir         <= 1'b1;
      r_sonuc_gecerli <= 1'b0;
      r_bolum         <= '0;
      r_kalan         <= '0;
    end else begin
      r_hazir         <= w_hazir_sonraki;
      r_sonuc_gecerli <= w_sonuc_yukle;
      if (w_sonuc_yukle) begin
        r_bolum <= w_bolum_son;
        r_kalan <= w_kalan_son;
      end
    end
  end

  assign hazir_o         = r_hazir;
  assign sonuc_gecerli_o = r_sonuc_gecerli;
  assign bolum_o         = r_bolum;
  assign kalan_o         = r_kalan;

endmodule

// File: tb/tb_bolucu_seq.sv
// Directed and model-checked bench for bolucu_seq.
module tb_bolucu_seq;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] islec0_i, islec1_i;
  logic        isaretli_i, islem_gecerli_i, iptal_i;
  logic        hazir_o, sonuc_gecerli_o;
  logic [31:0] bolum_o, kalan_o;

  int n_karsilastirma = 0;
  int n_hata          = 0;

  bolucu_seq dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .islec0_i        (islec0_i),
    .islec1_i        (islec1_i),
    .isaretli_i      (isaretli_i),
    .islem_gecerli_i (islem_gecerli_i),
    .hazir_o         (hazir_o),
    .iptal_i         (iptal_i),
    .bolum_o         (bolum_o),
    .kalan_o         (kalan_o),
    .sonuc_gecerli_o (sonuc_gecerli_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_karsilastirma++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got %h want %h", etiket, gozlenen, beklenen);
    end
  endtask

  // Reference RISC-V M-extension semantics.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Issue one request, wait for the pulse, check latency, busy flag and results.
  task automatic islem(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input string tag);
    int   n;
    logic hazir_gordu;
    kontrol({tag, "/hazir_once"}, 32'(hazir_o), 32'd1);
    islec0_i = a; islec1_i = b; isaretli_i = s; islem_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    islem_gecerli_i = 1'b0;
    hazir_gordu = 1'b0;
    n = 0;
    while (n < 60 && !sonuc_gecerli_o) begin
      if (hazir_o) hazir_gordu = 1'b1;
      @(posedge clk_i); #1;
      n++;
    end
    kontrol({tag, "/gecikme"}, 32'(n), 32'd34);
    kontrol({tag, "/hazir_dusuk"}, 32'(hazir_gordu), 32'd0);
    kontrol({tag, "/bolum"}, bolum_o, eq);
    kontrol({tag, "/kalan"}, kalan_o, er);
  endtask

  initial begin
    int          darbe;
    logic [31:0] a, b, eq, er;
    logic        s;

    rstn_i = 1'b0; islec0_i = '0; islec1_i = '0;
    isaretli_i = 1'b0; islem_gecerli_i = 1'b0; iptal_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    kontrol("rst/hazir", 32'(hazir_o), 32'd1);
    kontrol("rst/gecerli", 32'(sonuc_gecerli_o), 32'd0);
    kontrol("rst/bolum", bolum_o, 32'd0);
    kontrol("rst/kalan", kalan_o, 32'd0);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    islem(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7");
    // Pulse is one cycle wide; results are held afterwards.
    @(posedge clk_i); #1;
    kontrol("darbe_tek", 32'(sonuc_gecerli_o), 32'd0);
    kontrol("tut/bolum", bolum_o, 32'd14);
    kontrol("tut/kalan", kalan_o, 32'd2);

    islem(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s-7_2");
    islem(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "s7_-2");
    islem(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, "s_div0");
    islem(32'hDEAD_BEEF, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "u_div0");
    islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "s_ovf");
    islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, "u_ovf_ops");

    // Flush in the tenth BOL cycle.
    islec0_i = 32'd1000; islec1_i = 32'd3; isaretli_i = 1'b0; islem_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    islem_gecerli_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    iptal_i = 1'b1;
    @(posedge clk_i); #1;
    kontrol("iptal/hazir", 32'(hazir_o), 32'd1);
    kontrol("iptal/gecerli", 32'(sonuc_gecerli_o), 32'd0);
    // A request together with flush must not be taken.
    islem_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    islem_gecerli_i = 1'b0; iptal_i = 1'b0;
    kontrol("iptal/istek_red", 32'(hazir_o), 32'd1);
    kontrol("iptal/bolum", bolum_o, 32'd0);
    kontrol("iptal/kalan", kalan_o, 32'h8000_0000);
    darbe = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (sonuc_gecerli_o) darbe++;
    end
    kontrol("iptal/darbe_yok", 32'(darbe), 32'd0);
    islem(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "u9_3");

    // Back-to-back: each call issues in the previous pulse cycle.
    islem(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "b2b_a");
    islem(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "b2b_b");

    // Asynchronous reset in the middle of BOL.
    islec0_i = 32'd12345; islec1_i = 32'd11; isaretli_i = 1'b0; islem_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    islem_gecerli_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    #2;
    kontrol("arst/hazir", 32'(hazir_o), 32'd1);
    kontrol("arst/gecerli", 32'(sonuc_gecerli_o), 32'd0);
    kontrol("arst/bolum", bolum_o, 32'd0);
    kontrol("arst/kalan", kalan_o, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    darbe = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (sonuc_gecerli_o) darbe++;
    end
    kontrol("arst/darbe_yok", 32'(darbe), 32'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 10; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      if (i == 3) b = 32'hFFFF_FFFF;
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er);
      islem(a, b, s, eq, er, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
    $finish;
  end

endmodule
